// File: rtl/gpu_axi_regs_if.sv
// AXI4-lite bus bundle between the host and the GPU register bank.
// The master modport drives requests; the slave modport returns responses.
interface gpu_axi_regs_if #(
  parameter int SADDR_WIDTH = 32
);
  logic [SADDR_WIDTH-1:0] awaddr;
  logic [2:0]             awprot;
  logic                   awvalid;
  logic                   awready;
  logic [31:0]            wdata;
  logic [3:0]             wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [SADDR_WIDTH-1:0] araddr;
  logic [2:0]             arprot;
  logic                   arvalid;
  logic                   arready;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/gpu_axi_regs.sv
// AXI4-lite register bank and frame controller for the triangle pipeline.
// Optional GPU_FRAME_CNT_EN adds a read-only completed-frame counter at 0x14.
module gpu_axi_regs #(
  parameter int SADDR_WIDTH = 32,
  parameter int MADDR_WIDTH = 32,
  parameter int ADDR_DEC_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  gpu_axi_regs_if.slave          bus,
  input  logic                   frame_end,
  output logic                   frame_start,
  output logic                   busy,
  output logic [31:0]            triangles_count,
  output logic [MADDR_WIDTH-1:0] base_addr_vertex,
  output logic [MADDR_WIDTH-1:0] base_addr_color,
  output logic                   irq
);

  localparam logic [ADDR_DEC_W-1:0] A_CTRL   = ADDR_DEC_W'(8'h00);
  localparam logic [ADDR_DEC_W-1:0] A_STATUS = ADDR_DEC_W'(8'h04);
  localparam logic [ADDR_DEC_W-1:0] A_TRI    = ADDR_DEC_W'(8'h08);
  localparam logic [ADDR_DEC_W-1:0] A_VTX    = ADDR_DEC_W'(8'h0C);
  localparam logic [ADDR_DEC_W-1:0] A_COL    = ADDR_DEC_W'(8'h10);
  localparam logic [ADDR_DEC_W-1:0] A_FCNT   = ADDR_DEC_W'(8'h14);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {ST_IDLE, ST_BUSY} frame_state_t;

  // write holding slots and response
  logic                  aw_full_reg;
  logic [ADDR_DEC_W-1:0] aw_addr_reg;
  logic                  w_full_reg;
  logic [31:0]           w_data_reg;
  logic [3:0]            w_strb_reg;
  logic                  bvalid_reg;
  logic [1:0]            bresp_reg;

  // read response
  logic                  rvalid_reg;
  logic [31:0]           rdata_reg;
  logic [1:0]            rresp_reg;
  logic [31:0]           rd_data_next;
  logic [1:0]            rd_resp_next;

  // register file
  logic                  irq_en_reg;
  logic                  irq_pending_reg;
  logic                  irq_pending_next;
  logic [31:0]           tri_count_reg;
  logic [31:0]           tri_count_next;
  logic [31:0]           vtx_base_reg;
  logic [31:0]           vtx_base_next;
  logic [31:0]           col_base_reg;
  logic [31:0]           col_base_next;

  // frame FSM
  frame_state_t          state_reg;
  frame_state_t          state_next;
  logic                  frame_start_reg;
  logic                  frame_start_next;
  logic                  irq_set;

  logic                  write_fire;
  logic                  sel_ctrl;
  logic                  sel_status;
  logic                  sel_tri;
  logic                  sel_vtx;
  logic                  sel_col;
  logic                  wr_mapped;
  logic                  start_req;
  logic                  w1c_irq;
  logic [ADDR_DEC_W-1:0] rd_addr;

  // protection bits and address bits above the decoded window carry no meaning
  logic [SADDR_WIDTH-1:0] unused_addr_bits;
  logic                   unused_prot_bits;
  assign unused_addr_bits = bus.awaddr ^ bus.araddr;
  assign unused_prot_bits = ^{bus.awprot, bus.arprot};

  assign bus.awready = !aw_full_reg && !bvalid_reg;
  assign bus.wready  = !w_full_reg && !bvalid_reg;
  assign bus.bvalid  = bvalid_reg;
  assign bus.bresp   = bresp_reg;
  assign bus.arready = !rvalid_reg;
  assign bus.rvalid  = rvalid_reg;
  assign bus.rdata   = rdata_reg;
  assign bus.rresp   = rresp_reg;

  assign write_fire = aw_full_reg && w_full_reg && !bvalid_reg;
  assign sel_ctrl   = write_fire && (aw_addr_reg == A_CTRL);
  assign sel_status = write_fire && (aw_addr_reg == A_STATUS);
  assign sel_tri    = write_fire && (aw_addr_reg == A_TRI);
  assign sel_vtx    = write_fire && (aw_addr_reg == A_VTX);
  assign sel_col    = write_fire && (aw_addr_reg == A_COL);
`ifdef GPU_FRAME_CNT_EN
  assign wr_mapped  = sel_ctrl || sel_status || sel_tri || sel_vtx || sel_col ||
                      (aw_addr_reg == A_FCNT);
`else
  assign wr_mapped  = sel_ctrl || sel_status || sel_tri || sel_vtx || sel_col;
`endif
  assign start_req  = sel_ctrl && w_strb_reg[0] && w_data_reg[0];
  assign w1c_irq    = sel_status && w_strb_reg[0] && w_data_reg[1];

  // byte-lane merge for the plain read/write registers
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
      assign tri_count_next[8*gi +: 8] = (sel_tri && w_strb_reg[gi]) ?
                                         w_data_reg[8*gi +: 8] : tri_count_reg[8*gi +: 8];
      assign vtx_base_next[8*gi +: 8]  = (sel_vtx && w_strb_reg[gi]) ?
                                         w_data_reg[8*gi +: 8] : vtx_base_reg[8*gi +: 8];
      assign col_base_next[8*gi +: 8]  = (sel_col && w_strb_reg[gi]) ?
                                         w_data_reg[8*gi +: 8] : col_base_reg[8*gi +: 8];
    end
  endgenerate

  // a frame_end landing with the clear still leaves the interrupt pending
  assign irq_pending_next = irq_set || (irq_pending_reg && !w1c_irq);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_full_reg <= 1'b0;
      aw_addr_reg <= '0;
      w_full_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else if (write_fire) begin
      aw_full_reg <= 1'b0;
      w_full_reg  <= 1'b0;
      bvalid_reg  <= 1'b1;
      bresp_reg   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (bus.awvalid && bus.awready) begin
        aw_full_reg <= 1'b1;
        aw_addr_reg <= bus.awaddr[ADDR_DEC_W-1:0];
      end
      if (bus.wvalid && bus.wready) begin
        w_full_reg <= 1'b1;
        w_data_reg <= bus.wdata;
        w_strb_reg <= bus.wstrb;
      end
      if (bvalid_reg && bus.bready) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_reg      <= 1'b0;
      irq_pending_reg <= 1'b0;
      tri_count_reg   <= '0;
      vtx_base_reg    <= '0;
      col_base_reg    <= '0;
    end else begin
      if (sel_ctrl && w_strb_reg[0]) begin
        irq_en_reg <= w_data_reg[1];
      end
      irq_pending_reg <= irq_pending_next;
      tri_count_reg   <= tri_count_next;
      vtx_base_reg    <= vtx_base_next;
      col_base_reg    <= col_base_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      frame_start_reg <= frame_start_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    frame_start_next = 1'b0;
    irq_set          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_req && (tri_count_reg != 32'd0)) begin
          state_next       = ST_BUSY;
          frame_start_next = 1'b1;
        end
      end
      ST_BUSY: begin
        if (frame_end) begin
          state_next = ST_IDLE;
          irq_set    = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef GPU_FRAME_CNT_EN
  logic [31:0] frame_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_reg <= '0;
    end else if (irq_set) begin
      frame_cnt_reg <= frame_cnt_reg + 32'd1;
    end
  end
`endif

  assign rd_addr = bus.araddr[ADDR_DEC_W-1:0];

  always_comb begin
    rd_data_next = '0;
    rd_resp_next = RESP_OKAY;
    case (rd_addr)
      A_CTRL:   rd_data_next = {30'd0, irq_en_reg, 1'b0};
      A_STATUS: rd_data_next = {30'd0, irq_pending_reg, state_reg == ST_BUSY};
      A_TRI:    rd_data_next = tri_count_reg;
      A_VTX:    rd_data_next = vtx_base_reg;
      A_COL:    rd_data_next = col_base_reg;
`ifdef GPU_FRAME_CNT_EN
      A_FCNT:   rd_data_next = frame_cnt_reg;
`endif
      default:  rd_resp_next = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (bus.arvalid && bus.arready) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_data_next;
      rresp_reg  <= rd_resp_next;
    end else if (rvalid_reg && bus.rready) begin
      rvalid_reg <= 1'b0;
    end
  end

  assign frame_start      = frame_start_reg;
  assign busy             = (state_reg == ST_BUSY);
  assign triangles_count  = tri_count_reg;
  assign base_addr_vertex = vtx_base_reg[MADDR_WIDTH-1:0];
  assign base_addr_color  = col_base_reg[MADDR_WIDTH-1:0];
  assign irq              = irq_pending_reg && irq_en_reg;

endmodule

// File: tb/tb_gpu_axi_regs.sv
// Directed bench for gpu_axi_regs: a register-map model in the bench is checked
// against the DUT outputs every cycle, plus literal expectations on readbacks.
module tb_gpu_axi_regs;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_end = 1'b0;
  logic        frame_start;
  logic        busy;
  logic [31:0] triangles_count;
  logic [31:0] base_addr_vertex;
  logic [31:0] base_addr_color;
  logic        irq;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // specification-level model of the visible state
  logic [31:0] m_tri, m_vtx, m_col, m_cnt;
  bit          m_en, m_pend, m_busy, m_fs;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  gpu_axi_regs_if #(.SADDR_WIDTH(32)) bus ();

  gpu_axi_regs #(
    .SADDR_WIDTH(32),
    .MADDR_WIDTH(32),
    .ADDR_DEC_W (8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .bus             (bus),
    .frame_end       (frame_end),
    .frame_start     (frame_start),
    .busy            (busy),
    .triangles_count (triangles_count),
    .base_addr_vertex(base_addr_vertex),
    .base_addr_color (base_addr_color),
    .irq             (irq)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'd0, act}, {31'd0, exp});
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_tri = '0; m_vtx = '0; m_col = '0; m_cnt = '0;
    m_en = 0; m_pend = 0; m_busy = 0; m_fs = 0;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] d,
                             input logic [3:0] strb, output logic [1:0] resp);
    resp = 2'b00;
    case (addr[7:0])
      8'h00: if (strb[0]) begin
        m_en = d[1];
        if (d[0] && !m_busy && m_tri != 0) begin
          m_busy = 1;
          m_fs   = 1;
        end
      end
      8'h04: if (strb[0] && d[1]) m_pend = 0;
      8'h08: m_tri = merge(m_tri, d, strb);
      8'h0C: m_vtx = merge(m_vtx, d, strb);
      8'h10: m_col = merge(m_col, d, strb);
`ifdef GPU_FRAME_CNT_EN
      8'h14: resp = 2'b00;
`endif
      default: resp = 2'b10;
    endcase
  endtask

  task automatic model_frame_end();
    if (m_busy) begin
      m_busy = 0;
      m_pend = 1;
      m_cnt  = m_cnt + 1;
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] resp);
    d = '0;
    resp = 2'b00;
    case (addr[7:0])
      8'h00: d = {30'd0, m_en, 1'b0};
      8'h04: d = {30'd0, m_pend, m_busy};
      8'h08: d = m_tri;
      8'h0C: d = m_vtx;
      8'h10: d = m_col;
`ifdef GPU_FRAME_CNT_EN
      8'h14: d = m_cnt;
`endif
      default: resp = 2'b10;
    endcase
  endtask

  // per-cycle comparison of the pipeline-facing outputs
  always @(negedge clk) begin
    if (chk_en) begin
      check1("busy", busy, m_busy);
      check1("irq", irq, m_pend & m_en);
      check1("frame_start", frame_start, m_fs);
      check32("triangles_count", triangles_count, m_tri);
      check32("base_addr_vertex", base_addr_vertex, m_vtx);
      check32("base_addr_color", base_addr_color, m_col);
      m_fs = 0;
    end
  end

  // all tasks start and end at posedge+1
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input bit fe_fire, output logic [1:0] resp);
    int cyc;
    int aw_delay;
    bit aw_pend, w_pend, aw_hs, w_hs;
    logic [1:0] exp_resp;
    aw_pend = 1; w_pend = 1; aw_delay = w_lead; cyc = 0;
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.wvalid = 1'b1; bus.bready = 1'b1;
    while ((aw_pend || w_pend) && cyc < 40) begin
      if (aw_pend && aw_delay == 0) bus.awvalid = 1'b1;
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      if (aw_hs) begin bus.awvalid = 1'b0; aw_pend = 0; end
      if (w_hs)  begin bus.wvalid = 1'b0;  w_pend = 0;  end
      if (aw_delay > 0) aw_delay--;
      if (!w_pend && aw_pend) check1("wready_slot_full", bus.wready, 1'b0);
      cyc++;
    end
    check1("aw_w_accept_timeout", aw_pend || w_pend, 1'b0);
    if (fe_fire) frame_end = 1'b1;
    cyc = 0;
    while (!bus.bvalid && cyc < 10) begin
      @(posedge clk); #1;
      frame_end = 1'b0;
      cyc++;
    end
    frame_end = 1'b0;
    check32("bvalid_latency", cyc, 1);
    resp = bus.bresp;
    model_write(addr, data, strb, exp_resp);
    if (fe_fire) model_frame_end();
    check32("bresp", {30'd0, resp}, {30'd0, exp_resp});
    check1("awready_during_b", bus.awready, 1'b0);
    @(posedge clk); #1;
    bus.bready = 1'b0;
    check1("bvalid_single", bus.bvalid, 1'b0);
    $display("WR addr=0x%08h data=0x%08h strb=%b bresp=%b", addr, data, strb, resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    int cyc;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
    cyc = 0;
    while (!bus.arready && cyc < 10) begin @(posedge clk); #1; cyc++; end
    model_read(addr, exp_d, exp_r);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    check1("rvalid_rise", bus.rvalid, 1'b1);
    data = bus.rdata;
    resp = bus.rresp;
    check32("rdata", data, exp_d);
    check32("rresp", {30'd0, resp}, {30'd0, exp_r});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check1("rvalid_hold", bus.rvalid, 1'b1);
      check32("rdata_hold", bus.rdata, exp_d);
      check1("arready_hold", bus.arready, 1'b0);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    check1("rvalid_clear", bus.rvalid, 1'b0);
    $display("RD addr=0x%08h data=0x%08h rresp=%b", addr, data, resp);
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    model_frame_end();
    $display("FRAME_END busy=%b irq=%b", busy, irq);
  endtask

  task automatic check_reset_outputs();
    check1("rst_awready", bus.awready, 1'b1);
    check1("rst_wready", bus.wready, 1'b1);
    check1("rst_arready", bus.arready, 1'b1);
    check1("rst_bvalid", bus.bvalid, 1'b0);
    check1("rst_rvalid", bus.rvalid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_irq", irq, 1'b0);
    check1("rst_frame_start", frame_start, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // reset readback of the whole map
    for (int a = 0; a <= 'h10; a += 4) begin
      axi_read(a, 0, d, r);
      check32("reset_read_lit", d, 32'd0);
    end

    // W leads AW by three cycles
    axi_write(32'h08, 32'd5, 4'hF, 3, 0, r);
    axi_write(32'h0C, 32'h1000, 4'hF, 3, 0, r);
    axi_write(32'h10, 32'h2000, 4'hF, 3, 0, r);
    axi_read(32'h08, 0, d, r); check32("tri_lit", d, 32'd5);
    axi_read(32'h0C, 0, d, r); check32("vtx_lit", d, 32'h1000);
    axi_read(32'h10, 0, d, r); check32("col_lit", d, 32'h2000);

    // single byte lane
    axi_write(32'h0C, 32'hAABBCCDD, 4'b0010, 0, 0, r);
    axi_read(32'h0C, 0, d, r); check32("strb_lit", d, 32'h0000CC00);

    // frame with interrupt enabled
    axi_write(32'h00, 32'h3, 4'hF, 0, 0, r);
    check1("busy_lit", busy, 1'b1);
    axi_write(32'h00, 32'h3, 4'hF, 1, 0, r);
    check1("restart_ignored_lit", busy, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    pulse_frame_end();
    axi_read(32'h04, 0, d, r); check32("status_lit", d, 32'h2);
    check1("irq_lit", irq, 1'b1);
    axi_write(32'h04, 32'h2, 4'hF, 0, 0, r);
    check1("irq_clear_lit", irq, 1'b0);
    pulse_frame_end();

    // zero triangles and unmapped accesses
    axi_write(32'h08, 32'd0, 4'hF, 0, 0, r);
    axi_write(32'h00, 32'h3, 4'hF, 0, 0, r);
    check1("no_start_lit", busy, 1'b0);
    axi_read(32'h1C, 0, d, r);
    check32("unmapped_rdata_lit", d, 32'd0);
    check32("unmapped_rresp_lit", {30'd0, r}, 32'd2);
    axi_write(32'h20, 32'h1234, 4'hF, 0, 0, r);
    check32("unmapped_bresp_lit", {30'd0, r}, 32'd2);
    axi_read(32'h108, 0, d, r); check32("alias_lit", d, 32'd0);

    // held read response, then clear racing a frame_end
    axi_write(32'h08, 32'd5, 4'hF, 0, 0, r);
    axi_write(32'h00, 32'h3, 4'hF, 2, 0, r);
    axi_read(32'h04, 4, d, r); check32("status_busy_lit", d, 32'h1);
    axi_write(32'h04, 32'h2, 4'hF, 0, 1, r);
    axi_read(32'h04, 0, d, r); check32("set_wins_lit", d, 32'h2);
    check1("set_wins_irq_lit", irq, 1'b1);

    // third frame; counter when present
    axi_write(32'h00, 32'h3, 4'hF, 0, 0, r);
    repeat (3) @(posedge clk);
    #1;
    pulse_frame_end();
    axi_read(32'h14, 0, d, r);
`ifdef GPU_FRAME_CNT_EN
    check32("frame_cnt_lit", d, 32'd3);
    axi_write(32'h14, 32'hFFFF, 4'hF, 0, 0, r);
    check32("frame_cnt_wr_bresp_lit", {30'd0, r}, 32'd0);
`else
    check32("no_frame_cnt_rresp_lit", {30'd0, r}, 32'd2);
`endif

    // reset while a read response is outstanding
    bus.araddr = 32'h08; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    check1("pre_reset_rvalid", bus.rvalid, 1'b1);
    chk_en = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    check32("rst_tri", triangles_count, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    axi_read(32'h08, 0, d, r); check32("post_reset_tri_lit", d, 32'd0);
    axi_read(32'h04, 0, d, r); check32("post_reset_status_lit", d, 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
